// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      HALT     = 2'd3
   } state_t;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX is still producing.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             uses_rt,
   output logic             hit
);

   // $zero never carries a real dependency
   assign hit = memread && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// PC / pipeline-register sequencing for the 5-stage core: MEM wait > load-use > redirect.
// Optional watchdog on MEM_WAIT compiled in with PIPE_HAZARD_CTRL_WATCHDOG_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_hold_o,
   output logic [1:0]       pc_src_o,
   output logic             ifid_hold_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_stall_o,
   output logic             timeout_o
);

   if (TIMEOUT_CYCLES >= (2 ** TO_W)) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES does not fit in TO_W bits");
   end

   state_t state, next;
   logic   lu_hit;
   logic   mem_stall;
   logic   stall_all;
   logic   eval_run;
   logic   wd_expired;

   load_use_detect u_lud (
      .memread (idex_memread_i),
      .ex_rt   (idex_rt_i),
      .id_rs   (ifid_rs_i),
      .id_rt   (ifid_rt_i),
      .uses_rt (ifid_uses_rt_i),
      .hit     (lu_hit)
   );

   assign mem_stall = dmem_req_i && !dmem_ack_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= next;
   end

`ifdef PIPE_HAZARD_CTRL_WATCHDOG_EN
   logic [TO_W-1:0] wd_cnt;

   // counts completed MEM_WAIT cycles; anything other than staying in MEM_WAIT clears it
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                  wd_cnt <= '0;
      else if (state == MEM_WAIT && next == MEM_WAIT) wd_cnt <= wd_cnt + 1'b1;
      else                                         wd_cnt <= '0;
   end

   assign wd_expired = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o  = (state == HALT);
`else
   assign wd_expired = 1'b0;
   assign timeout_o  = 1'b0;
`endif

   always_comb begin
      next = state;
      unique case (state)
         IDLE:     if (start_i) next = RUN;
         RUN:      if (mem_stall) next = MEM_WAIT;
         MEM_WAIT: begin
            if (dmem_ack_i)      next = RUN;
            else if (wd_expired) next = HALT;
         end
         HALT:     next = HALT;
      endcase
      if (!start_i && state != HALT) next = IDLE;
   end

   assign stall_all = (state == IDLE) || (state == HALT) ||
                      (state == RUN && mem_stall) ||
                      (state == MEM_WAIT && !dmem_ack_i);
   // the ack cycle of MEM_WAIT behaves like an unstalled RUN cycle
   assign eval_run  = (state == RUN && !mem_stall) ||
                      (state == MEM_WAIT && dmem_ack_i);

   always_comb begin
      pc_hold_o     = 1'b0;
      pc_src_o      = PCSRC_SEQ;
      ifid_hold_o   = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_stall_o  = 1'b0;
      if (stall_all) begin
         pc_hold_o    = 1'b1;
         ifid_hold_o  = 1'b1;
         pipe_stall_o = 1'b1;
      end else if (eval_run) begin
         if (lu_hit) begin
            pc_hold_o     = 1'b1;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
         end else if (jump_i) begin
            ifid_flush_o = 1'b1;
            pc_src_o     = PCSRC_JMP;
         end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            pc_src_o     = PCSRC_BR;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; watchdog scenario runs when
// PIPE_HAZARD_CTRL_WATCHDOG_EN is defined.
module tb_pipe_hazard_ctrl;

   // packed view: {pc_hold, pc_src[1:0], ifid_hold, ifid_flush, idex_bubble, pipe_stall, timeout}
   localparam logic [7:0] O_HOLD  = 8'b1_00_1_0_0_1_0;
   localparam logic [7:0] O_CLEAR = 8'b0_00_0_0_0_0_0;
   localparam logic [7:0] O_LU    = 8'b1_00_1_0_1_0_0;
   localparam logic [7:0] O_BR    = 8'b0_01_0_1_0_0_0;
   localparam logic [7:0] O_JMP   = 8'b0_10_0_1_0_0_0;
   localparam logic [7:0] O_HALT  = 8'b1_00_1_0_0_1_1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       memread, uses_rt, branch, jump, req, ack;
   logic [4:0] ex_rt, id_rs, id_rt;
   logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_stall, timeout;
   logic [1:0] pc_src;
   logic [7:0] outs;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   assign outs = {pc_hold, pc_src, ifid_hold, ifid_flush, idex_bubble, pipe_stall, timeout};

   pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .idex_memread_i (memread),
      .idex_rt_i      (ex_rt),
      .ifid_rs_i      (id_rs),
      .ifid_rt_i      (id_rt),
      .ifid_uses_rt_i (uses_rt),
      .branch_taken_i (branch),
      .jump_i         (jump),
      .dmem_req_i     (req),
      .dmem_ack_i     (ack),
      .pc_hold_o      (pc_hold),
      .pc_src_o       (pc_src),
      .ifid_hold_o    (ifid_hold),
      .ifid_flush_o   (ifid_flush),
      .idex_bubble_o  (idex_bubble),
      .pipe_stall_o   (pipe_stall),
      .timeout_o      (timeout)
   );

   task automatic clear_inputs();
      memread = 1'b0; uses_rt = 1'b0; branch = 1'b0; jump = 1'b0;
      req = 1'b0; ack = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; clear_inputs();
      #1;
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL reset_state: got %b expected %b", outs, O_HOLD); end
      @(negedge clk); rst = 1'b1; start = 1'b1; #1;
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL start_before_edge: got %b expected %b", outs, O_HOLD); end
      @(negedge clk); #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL first_run_cycle: got %b expected %b", outs, O_CLEAR); end
   endtask

   task automatic test_load_use();
      @(negedge clk); memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
      n_checks++;
      if (outs !== O_LU) begin n_fail++; $display("FAIL lu_rs: got %b expected %b", outs, O_LU); end
      @(negedge clk); memread = 1'b0; #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL lu_after_bubble: got %b expected %b", outs, O_CLEAR); end
      memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL lu_reg_zero: got %b expected %b", outs, O_CLEAR); end
      ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; uses_rt = 1'b1; #1;
      n_checks++;
      if (outs !== O_LU) begin n_fail++; $display("FAIL lu_rt: got %b expected %b", outs, O_LU); end
      uses_rt = 1'b0; #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL lu_rt_not_used: got %b expected %b", outs, O_CLEAR); end
      uses_rt = 1'b1; branch = 1'b1; #1;
      n_checks++;
      if (outs !== O_LU) begin n_fail++; $display("FAIL lu_over_branch: got %b expected %b", outs, O_LU); end
      clear_inputs();
   endtask

   task automatic test_redirect();
      @(negedge clk); branch = 1'b1; #1;
      n_checks++;
      if (outs !== O_BR) begin n_fail++; $display("FAIL branch: got %b expected %b", outs, O_BR); end
      jump = 1'b1; #1;
      n_checks++;
      if (outs !== O_JMP) begin n_fail++; $display("FAIL jump_wins: got %b expected %b", outs, O_JMP); end
      branch = 1'b0; #1;
      n_checks++;
      if (outs !== O_JMP) begin n_fail++; $display("FAIL jump_only: got %b expected %b", outs, O_JMP); end
      @(negedge clk); clear_inputs(); #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL redirect_one_cycle: got %b expected %b", outs, O_CLEAR); end
   endtask

   task automatic test_mem_wait();
      @(negedge clk); req = 1'b1; branch = 1'b1; memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL mem_stall_run: got %b expected %b", outs, O_HOLD); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (outs !== O_HOLD) begin n_fail++; $display("FAIL mem_wait_%0d: got %b expected %b", i, outs, O_HOLD); end
      end
      @(negedge clk); ack = 1'b1; memread = 1'b0; #1;
      n_checks++;
      if (outs !== O_BR) begin n_fail++; $display("FAIL mem_ack_redirect: got %b expected %b", outs, O_BR); end
      @(negedge clk); clear_inputs(); #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL mem_back_to_run: got %b expected %b", outs, O_CLEAR); end
      req = 1'b1; ack = 1'b1; branch = 1'b1; #1;
      n_checks++;
      if (outs !== O_BR) begin n_fail++; $display("FAIL req_ack_same_cycle: got %b expected %b", outs, O_BR); end
      @(negedge clk); clear_inputs(); #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL no_wait_after_req_ack: got %b expected %b", outs, O_CLEAR); end
   endtask

   task automatic test_stop();
      @(negedge clk); start = 1'b0; #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL stop_same_cycle: got %b expected %b", outs, O_CLEAR); end
      @(negedge clk); #1;
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL stop_to_idle: got %b expected %b", outs, O_HOLD); end
      start = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL restart: got %b expected %b", outs, O_CLEAR); end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk); req = 1'b1; #1;
      @(negedge clk); ack = 1'b1; branch = 1'b1; #1;
      n_checks++;
      if (outs !== O_BR) begin n_fail++; $display("FAIL wait_ack_before_reset: got %b expected %b", outs, O_BR); end
      #1 rst = 1'b0; #1;
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL reset_mid_wait: got %b expected %b", outs, O_HOLD); end
      @(negedge clk); rst = 1'b1; clear_inputs();
      @(negedge clk); #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL run_after_reset: got %b expected %b", outs, O_CLEAR); end
   endtask

`ifdef PIPE_HAZARD_CTRL_WATCHDOG_EN
   task automatic test_watchdog();
      // two MEM_WAIT cycles, then reset: the count must not carry over
      @(negedge clk); req = 1'b1;
      @(negedge clk);
      @(negedge clk); #1 rst = 1'b0; #1;
      @(negedge clk); rst = 1'b1; clear_inputs();
      @(negedge clk); req = 1'b1; #1;
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL wd_stall_run: got %b expected %b", outs, O_HOLD); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (outs !== O_HOLD) begin n_fail++; $display("FAIL wd_wait_%0d: got %b expected %b", i, outs, O_HOLD); end
      end
      @(negedge clk); #1;
      n_checks++;
      if (outs !== O_HALT) begin n_fail++; $display("FAIL wd_halt: got %b expected %b", outs, O_HALT); end
      ack = 1'b1; start = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (outs !== O_HALT) begin n_fail++; $display("FAIL wd_sticky: got %b expected %b", outs, O_HALT); end
      rst = 1'b0; #1;
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL wd_reset: got %b expected %b", outs, O_HOLD); end
      @(negedge clk); rst = 1'b1; start = 1'b1; clear_inputs();
      @(negedge clk); #1;
      n_checks++;
      if (outs !== O_CLEAR) begin n_fail++; $display("FAIL wd_run_after_reset: got %b expected %b", outs, O_CLEAR); end
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_stop();
      test_reset_mid_wait();
`ifdef PIPE_HAZARD_CTRL_WATCHDOG_EN
      test_watchdog();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It decides each cycle whether the PC register advances, holds or takes a redirect. It also decides whether the IF/ID, ID/EX and later pipeline registers advance, hold, flush or take a bubble. It arbitrates three stall/redirect sources in fixed priority: data-memory wait, load-use hazard, then branch/jump redirect. Its `pc_hold_o` drives the PC register's hold select, and `pc_src_o` drives the next-PC mux.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum MEM_WAIT cycles before the watchdog trips (used only with the watchdog macro).
- `TO_W`, default 8: watchdog counter width; must satisfy `TIMEOUT_CYCLES < 2**TO_W`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  core run enable; low freezes the pipeline.
- `idex_memread_i`  in  1  instruction in EX is a load.
- `idex_rt_i`  in  5  load destination register in EX.
- `ifid_rs_i`  in  5  rs of the instruction in ID.
- `ifid_rt_i`  in  5  rt of the instruction in ID.
- `ifid_uses_rt_i`  in  1  ID instruction reads rt.
- `branch_taken_i`  in  1  branch resolved taken in ID.
- `jump_i`  in  1  jump decoded in ID.
- `dmem_req_i`  in  1  MEM-stage access pending.
- `dmem_ack_i`  in  1  data memory completes the access this cycle.
- `pc_hold_o`  out  1  PC keeps its value.
- `pc_src_o`  out  2  next-PC select: 00 sequential, 01 branch target, 10 jump target.
- `ifid_hold_o`  out  1  IF/ID register holds.
- `ifid_flush_o`  out  1  IF/ID register loads a NOP.
- `idex_bubble_o`  out  1  ID/EX register loads control zeros.
- `pipe_stall_o`  out  1  ID/EX, EX/MEM and MEM/WB registers hold.
- `timeout_o`  out  1  watchdog tripped (sticky).

## Operation
- States: IDLE, RUN, MEM_WAIT, HALT. State is registered; all outputs are combinational from the state and the current inputs.
- IDLE: `pc_hold_o`, `ifid_hold_o` and `pipe_stall_o` are 1; all other outputs are 0.
  - `start_i` = 1 → RUN.
- `start_i` = 0 in any state except HALT → IDLE at the next edge.
- RUN, in priority order (first match applies):
  1. MEM stall, when `dmem_req_i` && !`dmem_ack_i`:
     - `pc_hold_o`, `ifid_hold_o` and `pipe_stall_o` are 1.
     - Branch, jump and load-use inputs are ignored.
     - Next state MEM_WAIT.
  2. Load-use, when `idex_memread_i` && `idex_rt_i` != 0 && (`idex_rt_i` == `ifid_rs_i` || (`ifid_uses_rt_i` && `idex_rt_i` == `ifid_rt_i`)):
     - `pc_hold_o`, `ifid_hold_o` and `idex_bubble_o` are 1.
     - `pc_src_o` = 00; a branch in ID is not honoured this cycle.
  3. Redirect, when `branch_taken_i` or `jump_i`:
     - `ifid_flush_o` = 1.
     - `pc_src_o` = 10 if `jump_i` is set, otherwise 01 (jump wins if both are set).
  4. Otherwise all control outputs are 0 and `pc_src_o` = 00.
- MEM_WAIT:
  - Same outputs as a RUN MEM stall while `dmem_ack_i` = 0.
  - On the cycle `dmem_ack_i` = 1, the stall outputs drop and the RUN rules (2)–(4) are evaluated on the current inputs. Next state is RUN.
- HALT: all hold/stall outputs are 1 and `timeout_o` = 1. Exited only by reset.

## Timing
- Reset values: state IDLE; `pc_hold_o` = `ifid_hold_o` = `pipe_stall_o` = 1; `pc_src_o` = 00; `ifid_flush_o` = `idex_bubble_o` = `timeout_o` = 0; watchdog counter = 0.
- Zero-latency control: outputs respond combinationally within the same cycle as their inputs.
- Load-use stall lasts exactly 1 cycle; the bubble clears `idex_memread_i` on the following cycle.
- If `dmem_req_i` and `dmem_ack_i` are both 1 in the same RUN cycle, there is no stall.
- A MEM stall lasting N cycles before the ack holds the pipeline for exactly N cycles.
- A redirect flush is 1 cycle wide. The PC loads the target at the same edge that IF/ID loads the NOP.
- Reset asserted mid-MEM_WAIT or mid-HALT → IDLE immediately; the counter clears.

## Configuration
- Macro `PIPE_HAZARD_CTRL_WATCHDOG_EN`, with the watchdog compiled in:
  - The counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
  - When the counter reaches `TIMEOUT_CYCLES` without an ack, next state is HALT and `timeout_o` becomes 1.
- Without the macro:
  - No counter and no HALT state.
  - MEM_WAIT waits indefinitely.
  - `timeout_o` is tied to 0.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, MEM_WAIT, HALT);
  - `pc_src_o` encodings `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_JMP`;
  - register-index width 5.
- Sub-module `load_use_detect`: purely combinational register comparator producing the load-use hit. The priority/state logic stays in the top module.

## Test plan
- Reset then `start_i` = 1: outputs hold until the first edge after start. Next cycle, all outputs are 0 with `pc_src_o` = 00.
- Load-use: `idex_memread_i` = 1, `idex_rt_i` = 8, `ifid_rs_i` = 8 → one cycle of `pc_hold_o` = `ifid_hold_o` = `idex_bubble_o` = 1. With `idex_rt_i` = 0 → no stall.
- Branch: `branch_taken_i` = 1 → `pc_src_o` = 01 and `ifid_flush_o` = 1 for 1 cycle. With `jump_i` = 1 as well → `pc_src_o` = 10.
- `dmem_req_i` = 1 with ack arriving 3 cycles later, plus `branch_taken_i` held throughout:
  - `pipe_stall_o` = 1 for 3 cycles;
  - on the ack cycle, `ifid_flush_o` = 1 and `pc_src_o` = 01.
- Watchdog built in, `TIMEOUT_CYCLES` = 4, no ack → HALT with `timeout_o` = 1 after 4 MEM_WAIT cycles. A later ack has no effect; only `rst_i` low clears it.
- Reset pulsed during MEM_WAIT → IDLE outputs immediately; the counter restarts from 0 on the next MEM_WAIT.
